fu_cdb_select: RTL
==================

Name: fu_cdb_select

Overview:
- Consumer end of the FU result interface. Takes the `prepared` bits and FU_STATE_PACKET from the FU bank and arbitrates up to NUM_CDB completed results per cycle onto the CDB and the ROB completion ports.
- Returns per-FU `avail` the same cycle so granted or idle FUs advance and losers hold.
- Sits between the FU bank and the CDB, PRF, RS wakeup and ROB.

Parameters:
- NUM_ALU, `NUM_FU_ALU, number of ALU requesters.
- NUM_MULT, `NUM_FU_MULT, number of multiplier requesters.
- NUM_LOAD, `NUM_FU_LOAD, number of load requesters.
- NUM_CDB, `CDB_SZ, broadcast slots per cycle; must satisfy 1 ≤ NUM_CDB ≤ N, where N = NUM_ALU+NUM_MULT+NUM_LOAD.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- squash  in  1  mispredict flush
- fu_state_packet  in  FU_STATE_PACKET  prepared bits and result packets of all FUs
- alu_avail  out  NUM_ALU  result accepted or FU idle
- mult_avail  out  NUM_MULT  same, per multiplier
- load_avail  out  NUM_LOAD  same, per load unit
- cdb_valid  out  NUM_CDB  slot carries a register writeback
- cdb_packet  out  CDB_PACKET[NUM_CDB]  {dest_prn, value}
- fu_rob_packet  out  FU_ROB_PACKET[NUM_CDB]  {robn, executed, branch_taken, target_addr}
- stat_broadcasts  out  32  broadcast counter (optional feature)
- stat_conflicts  out  32  conflict-cycle counter (optional feature)

Behaviour:
- Flattened requester index i in [0,N): ALU0..ALU(NUM_ALU-1), then MULT0.., then LOAD0...
- req[i] = the corresponding prepared bit.
- rr_ptr: register, width $clog2(N); resets to 0.

Grant (combinational):
- Scan i = rr_ptr, rr_ptr+1, … mod N.
- Grant the first NUM_CDB requesters with req set.
- Slot k receives the k-th grant in scan order. Slots without a grant carry nothing.

Avail (combinational, same cycle):
- avail[i] = !req[i] || grant[i].
- When squash=1, all avail = 1 and no grants are made.
- avail must not depend combinationally on any output register.

Pointer update:
- If at least one grant and squash=0: rr_ptr <= (index of last grant + 1) mod N, wrapping N-1 → 0.
- Otherwise rr_ptr holds.

Output registers (1-cycle latency: grant at edge t appears on outputs after edge t+1):
- Granted slot k:
  - fu_rob_packet[k].robn = basic.robn; executed = 1.
  - cdb_packet[k] = {basic.dest_prn, basic.result}.
  - cdb_valid[k] = (dest_prn != 0).
- ALU grant:
  - branch_taken = (cond_branch && take_branch) || uncond_branch.
  - target_addr = basic.result when branch_taken, else 0.
  - For uncond_branch, cdb value = PC + 4 (link register).
- MULT or LOAD grant: branch_taken = 0, target_addr = 0.
- Ungranted slot: executed = 0, cdb_valid = 0, all other fields 0.

Boundary conditions:
- Reset: all outputs 0; cdb_valid = 0; executed = 0; rr_ptr = 0. Holding reset for a cycle mid-stream drops in-flight register contents.
- squash: next edge clears all output registers. rr_ptr holds. Any grant computed that cycle is discarded.
- Fewer than NUM_CDB requests: all granted, remaining slots idle.
- Zero requests: outputs cleared next edge.
- A losing requester keeps its prepared bit and packet stable (FU contract). Rotation guarantees it is granted within ceil(N/NUM_CDB) cycles.
- reset and squash asserted together: reset wins.

Optional Feature:
- Macro FU_CDB_STATS_EN.
- Defined:
  - stat_broadcasts += number of granted slots per cycle.
  - stat_conflicts += 1 each cycle the number of requests exceeds NUM_CDB.
  - Both 32-bit, wrap at 2^32, cleared on reset, not affected by squash.
- Undefined: both ports tied to 0 and no counter logic is instantiated.

Test Plan:
(Configuration for all tests: NUM_ALU=3, NUM_MULT=2, NUM_LOAD=1, NUM_CDB=2.)
- Reset, then ALU1 only prepared (dest_prn=5, result=0x1234, robn=3) -> alu_avail=3'b111. Next cycle cdb_valid=2'b01, slot0={5,0x1234}, rob robn=3, executed=1. rr_ptr=2.
- All 6 requesters prepared and held, rr_ptr=0 -> grants {0,1}, then {2,3}, then {4,5}, then {0,1}. Loser avail=0 throughout. stat_conflicts +1 each cycle (feature on).
- rr_ptr=5, requesters 5 and 0 prepared -> slot0=LOAD0, slot1=ALU0; rr_ptr wraps to 1.
- ALU0 cond_branch=1, take_branch=1, result=0x400 -> branch_taken=1, target_addr=0x400. Same with take_branch=0 -> branch_taken=0, target_addr=0.
- MULT0 prepared with dest_prn=0 -> cdb_valid[0]=0, fu_rob_packet[0].executed=1.
- squash asserted with 3 requests pending -> all avail=1, no grants, outputs 0 next cycle, rr_ptr unchanged.

Source files
------------

// File: rtl/fu_cdb_select_if.sv
// ============================================================================
// Module      : fu_cdb_select_if
// Description : Bundle between the FU bank and the CDB selector. Carries the
//               FU state packet (prepared bits plus per-FU result fields), the
//               per-FU avail returns, and the registered CDB / ROB completion
//               slots. Flattened requester order is ALU0.., MULT0.., LOAD0..
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef NUM_FU_ALU
`define NUM_FU_ALU 3
`endif
`ifndef NUM_FU_MULT
`define NUM_FU_MULT 2
`endif
`ifndef NUM_FU_LOAD
`define NUM_FU_LOAD 1
`endif
`ifndef CDB_SZ
`define CDB_SZ 2
`endif

interface fu_cdb_select_if #(
  parameter int NUM_ALU  = `NUM_FU_ALU,
  parameter int NUM_MULT = `NUM_FU_MULT,
  parameter int NUM_LOAD = `NUM_FU_LOAD,
  parameter int NUM_CDB  = `CDB_SZ,
  parameter int PRN_W    = 6,
  parameter int ROB_W    = 5,
  parameter int XLEN     = 32
);
  localparam int c_num_req = NUM_ALU + NUM_MULT + NUM_LOAD;

  // FU state packet: prepared bits
  logic [NUM_ALU-1:0]                 alu_prepared;
  logic [NUM_MULT-1:0]                mult_prepared;
  logic [NUM_LOAD-1:0]                load_prepared;
  // FU state packet: basic result fields, indexed by flattened requester
  logic [c_num_req-1:0][ROB_W-1:0]    robn;
  logic [c_num_req-1:0][PRN_W-1:0]    dest_prn;
  logic [c_num_req-1:0][XLEN-1:0]     result;
  // FU state packet: ALU-only branch fields
  logic [NUM_ALU-1:0][XLEN-1:0]       alu_pc;
  logic [NUM_ALU-1:0]                 alu_cond_branch;
  logic [NUM_ALU-1:0]                 alu_take_branch;
  logic [NUM_ALU-1:0]                 alu_uncond_branch;

  // Same-cycle acceptance back to the FUs
  logic [NUM_ALU-1:0]                 alu_avail;
  logic [NUM_MULT-1:0]                mult_avail;
  logic [NUM_LOAD-1:0]                load_avail;

  // CDB packet slots {dest_prn, value}
  logic [NUM_CDB-1:0]                 cdb_valid;
  logic [NUM_CDB-1:0][PRN_W-1:0]      cdb_dest_prn;
  logic [NUM_CDB-1:0][XLEN-1:0]       cdb_value;

  // ROB completion slots {robn, executed, branch_taken, target_addr}
  logic [NUM_CDB-1:0][ROB_W-1:0]      rob_robn;
  logic [NUM_CDB-1:0]                 rob_executed;
  logic [NUM_CDB-1:0]                 rob_branch_taken;
  logic [NUM_CDB-1:0][XLEN-1:0]       rob_target_addr;

  // Statistics
  logic [31:0]                        stat_broadcasts;
  logic [31:0]                        stat_conflicts;

  // FU bank side
  modport master (
    output alu_prepared, mult_prepared, load_prepared,
    output robn, dest_prn, result,
    output alu_pc, alu_cond_branch, alu_take_branch, alu_uncond_branch,
    input  alu_avail, mult_avail, load_avail,
    input  cdb_valid, cdb_dest_prn, cdb_value,
    input  rob_robn, rob_executed, rob_branch_taken, rob_target_addr,
    input  stat_broadcasts, stat_conflicts
  );

  // Selector side
  modport slave (
    input  alu_prepared, mult_prepared, load_prepared,
    input  robn, dest_prn, result,
    input  alu_pc, alu_cond_branch, alu_take_branch, alu_uncond_branch,
    output alu_avail, mult_avail, load_avail,
    output cdb_valid, cdb_dest_prn, cdb_value,
    output rob_robn, rob_executed, rob_branch_taken, rob_target_addr,
    output stat_broadcasts, stat_conflicts
  );
endinterface

`default_nettype wire

// File: rtl/fu_cdb_select.sv
// ============================================================================
// Module      : fu_cdb_select
// Description : Round-robin selector of up to NUM_CDB completed FU results per
//               cycle onto the CDB and ROB completion slots. Avail is returned
//               combinationally; slot contents are registered (1-cycle).
//               Optional counters enabled by macro FU_CDB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef NUM_FU_ALU
`define NUM_FU_ALU 3
`endif
`ifndef NUM_FU_MULT
`define NUM_FU_MULT 2
`endif
`ifndef NUM_FU_LOAD
`define NUM_FU_LOAD 1
`endif
`ifndef CDB_SZ
`define CDB_SZ 2
`endif

module fu_cdb_select #(
  parameter int NUM_ALU  = `NUM_FU_ALU,
  parameter int NUM_MULT = `NUM_FU_MULT,
  parameter int NUM_LOAD = `NUM_FU_LOAD,
  parameter int NUM_CDB  = `CDB_SZ,
  parameter int PRN_W    = 6,
  parameter int ROB_W    = 5,
  parameter int XLEN     = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           squash,
  fu_cdb_select_if.slave bus
);
  localparam int c_num_req = NUM_ALU + NUM_MULT + NUM_LOAD;
  localparam int c_ptr_w   = (c_num_req > 1) ? $clog2(c_num_req) : 1;
  localparam int c_cnt_w   = $clog2(NUM_CDB + 1);

  logic [c_num_req-1:0]               w_req;
  logic [c_num_req-1:0]               w_grant;
  logic [c_num_req-1:0]               w_avail;
  logic [NUM_CDB-1:0]                 w_slot_vld;
  logic [NUM_CDB-1:0][c_ptr_w-1:0]    w_slot_sel;
  logic [c_ptr_w-1:0]                 w_last;
  logic [c_ptr_w-1:0]                 w_next_ptr;
  logic [c_ptr_w:0]                   w_scan_sum;
  logic [c_ptr_w-1:0]                 w_scan_idx;
  logic [c_cnt_w-1:0]                 w_num_grant;
  logic [c_ptr_w-1:0]                 r_rr_ptr;

  logic [NUM_CDB-1:0]                 w_nxt_valid;
  logic [NUM_CDB-1:0][PRN_W-1:0]      w_nxt_dest;
  logic [NUM_CDB-1:0][XLEN-1:0]       w_nxt_value;
  logic [NUM_CDB-1:0][ROB_W-1:0]      w_nxt_robn;
  logic [NUM_CDB-1:0]                 w_nxt_exec;
  logic [NUM_CDB-1:0]                 w_nxt_taken;
  logic [NUM_CDB-1:0][XLEN-1:0]       w_nxt_target;

  logic [NUM_CDB-1:0]                 r_cdb_valid;
  logic [NUM_CDB-1:0][PRN_W-1:0]      r_cdb_dest;
  logic [NUM_CDB-1:0][XLEN-1:0]       r_cdb_value;
  logic [NUM_CDB-1:0][ROB_W-1:0]      r_rob_robn;
  logic [NUM_CDB-1:0]                 r_rob_exec;
  logic [NUM_CDB-1:0]                 r_rob_taken;
  logic [NUM_CDB-1:0][XLEN-1:0]       r_rob_target;

  assign w_req = {bus.load_prepared, bus.mult_prepared, bus.alu_prepared};

  // Scan from the rotating pointer and hand out slots in scan order
  always_comb begin
    w_grant     = '0;
    w_slot_vld  = '0;
    w_slot_sel  = '0;
    w_last      = r_rr_ptr;
    w_num_grant = '0;
    w_scan_sum  = '0;
    w_scan_idx  = '0;
    for (int off = 0; off < c_num_req; off++) begin
      w_scan_sum = {1'b0, r_rr_ptr} + (c_ptr_w+1)'(off);
      if (w_scan_sum >= (c_ptr_w+1)'(c_num_req)) begin
        w_scan_sum = w_scan_sum - (c_ptr_w+1)'(c_num_req);
      end
      w_scan_idx = w_scan_sum[c_ptr_w-1:0];
      if (!squash && w_req[w_scan_idx] && (w_num_grant < c_cnt_w'(NUM_CDB))) begin
        w_grant[w_scan_idx] = 1'b1;
        for (int k = 0; k < NUM_CDB; k++) begin
          if (w_num_grant == c_cnt_w'(k)) begin
            w_slot_vld[k] = 1'b1;
            w_slot_sel[k] = w_scan_idx;
          end
        end
        w_last      = w_scan_idx;
        w_num_grant = w_num_grant + c_cnt_w'(1);
      end
    end
  end

  // Idle or granted FUs may advance; a squash releases every FU
  assign w_avail = squash ? {c_num_req{1'b1}} : (~w_req | w_grant);
  assign bus.alu_avail  = w_avail[NUM_ALU-1:0];
  assign bus.mult_avail = w_avail[NUM_ALU+NUM_MULT-1:NUM_ALU];
  assign bus.load_avail = w_avail[c_num_req-1:NUM_ALU+NUM_MULT];

  // Pointer moves just past the last grant, wrapping at the end of the list
  assign w_next_ptr = (w_last == c_ptr_w'(c_num_req - 1)) ? '0 : (w_last + c_ptr_w'(1));

  // Build next slot contents from the selected requester's packet
  always_comb begin
    w_nxt_valid  = '0;
    w_nxt_dest   = '0;
    w_nxt_value  = '0;
    w_nxt_robn   = '0;
    w_nxt_exec   = '0;
    w_nxt_taken  = '0;
    w_nxt_target = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      for (int i = 0; i < c_num_req; i++) begin
        if (w_slot_vld[k] && (w_slot_sel[k] == c_ptr_w'(i))) begin
          w_nxt_robn[k]  = bus.robn[i];
          w_nxt_exec[k]  = 1'b1;
          w_nxt_dest[k]  = bus.dest_prn[i];
          w_nxt_value[k] = bus.result[i];
        end
      end
      // Branch resolution only exists on ALUs; jumps write the link address
      for (int a = 0; a < NUM_ALU; a++) begin
        if (w_slot_vld[k] && (w_slot_sel[k] == c_ptr_w'(a))) begin
          w_nxt_taken[k]  = (bus.alu_cond_branch[a] && bus.alu_take_branch[a]) ||
                            bus.alu_uncond_branch[a];
          w_nxt_target[k] = w_nxt_taken[k] ? bus.result[a] : '0;
          if (bus.alu_uncond_branch[a]) begin
            w_nxt_value[k] = bus.alu_pc[a] + XLEN'(4);
          end
        end
      end
      w_nxt_valid[k] = w_nxt_exec[k] && (w_nxt_dest[k] != '0);
    end
  end

  // Round-robin pointer: reset to 0, holds on squash or when nothing granted
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (|w_grant) begin
      r_rr_ptr <= w_next_ptr;
    end
  end

  // Output slot registers: cleared on reset or squash
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      r_cdb_valid  <= '0;
      r_cdb_dest   <= '0;
      r_cdb_value  <= '0;
      r_rob_robn   <= '0;
      r_rob_exec   <= '0;
      r_rob_taken  <= '0;
      r_rob_target <= '0;
    end else begin
      r_cdb_valid  <= w_nxt_valid;
      r_cdb_dest   <= w_nxt_dest;
      r_cdb_value  <= w_nxt_value;
      r_rob_robn   <= w_nxt_robn;
      r_rob_exec   <= w_nxt_exec;
      r_rob_taken  <= w_nxt_taken;
      r_rob_target <= w_nxt_target;
    end
  end

  assign bus.cdb_valid        = r_cdb_valid;
  assign bus.cdb_dest_prn     = r_cdb_dest;
  assign bus.cdb_value        = r_cdb_value;
  assign bus.rob_robn         = r_rob_robn;
  assign bus.rob_executed     = r_rob_exec;
  assign bus.rob_branch_taken = r_rob_taken;
  assign bus.rob_target_addr  = r_rob_target;

`ifdef FU_CDB_STATS_EN
  localparam int c_rcnt_w = $clog2(c_num_req + 1);

  logic [c_rcnt_w-1:0] w_req_cnt;
  logic [31:0]         r_stat_broadcasts;
  logic [31:0]         r_stat_conflicts;

  // Count raw requests to detect oversubscribed cycles
  always_comb begin
    w_req_cnt = '0;
    for (int i = 0; i < c_num_req; i++) begin
      w_req_cnt = w_req_cnt + c_rcnt_w'(w_req[i]);
    end
  end

  // Free-running counters, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_broadcasts <= '0;
      r_stat_conflicts  <= '0;
    end else begin
      r_stat_broadcasts <= r_stat_broadcasts + 32'(w_num_grant);
      if (w_req_cnt > c_rcnt_w'(NUM_CDB)) begin
        r_stat_conflicts <= r_stat_conflicts + 32'd1;
      end
    end
  end

  assign bus.stat_broadcasts = r_stat_broadcasts;
  assign bus.stat_conflicts  = r_stat_conflicts;
`else
  assign bus.stat_broadcasts = '0;
  assign bus.stat_conflicts  = '0;
`endif

endmodule

`default_nettype wire
